// File: rtl/iter_sequencer.sv
// Iteration sequencer: steps an index from 0 to a latched limit,
// one-shot or wrapping, with a registered completion pulse.
module iter_sequencer #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] niter,
    input  logic                 mode,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 busy,
    output logic                 first,
    output logic                 last,
    output logic                 done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_nxt;
    logic [CNT_WIDTH-1:0] r_lim;
    logic [CNT_WIDTH-1:0] w_lim_nxt;
    logic                 r_mode;
    logic                 w_mode_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_at_lim;

    assign w_at_lim = (r_count == r_lim);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_lim   <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_lim   <= w_lim_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Priority is abort > start > enable, in either state.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_lim_nxt   = r_lim;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else if (start) begin
            w_state_nxt = RUN;
            w_count_nxt = '0;
            w_lim_nxt   = niter;
            w_mode_nxt  = mode;
        end else if (r_state == RUN && enable) begin
            if (!w_at_lim) begin
                w_count_nxt = r_count + 1'b1;
            end else if (r_mode) begin
                w_count_nxt = '0;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    assign count = r_count;
    assign done  = r_done;
    assign busy  = (r_state == RUN);
    assign first = busy && (r_count == '0);
    assign last  = busy && w_at_lim;

endmodule
